// File: rtl/computef_sweep_checker.sv
// ---------------------------------------------------------------------------
// computef_sweep_checker
//
// Stimulus driver and response checker for the 5-input CMOS function block
//   F = ~((A & D) | (E & (B | C)))
// Walks all 32 input vectors {a,b,c,d,e}. Each vector is held for
// SETTLE_CYCLES cycles so the switch-level network can settle. F is then
// sampled for one cycle and compared with the golden expression. The block
// reports the mismatch count, the first failing vector and a pass flag.
//
// Parameters:
//   SETTLE_CYCLES    cycles each vector is held before F is sampled (1..15)
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   rst_n            asynchronous active-low reset
//   start            sweep request; only accepted in IDLE or DONE
//   a..e             registered drive to the function block inputs A..E
//   f_in             F returned from the function block
//   busy             high while a sweep is in progress
//   done             sweep complete; level, held until the next start
//   pass             done with zero mismatches
//   err_count        number of mismatching vectors (0..32)
//   first_fail_vec   vector {a,b,c,d,e} of the first mismatch
//   first_fail_valid first_fail_vec holds a captured vector
// ---------------------------------------------------------------------------
module computef_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    input  logic       f_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [4:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // The counter is loaded with SETTLE_CYCLES-1 and the state advances on
    // the edge where it reads zero. SETTLE therefore lasts exactly
    // SETTLE_CYCLES cycles.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [4:0] vec;
    logic [3:0] cnt;
    logic       expected;
    logic       mismatch;

    // Vector bits map as vec = {a,b,c,d,e}.
    assign {a, b, c, d, e} = vec;
    assign pass = done & (err_count == 6'd0);

    // The mismatch flag defaults to 1 and is cleared only on a definite
    // equality. An X or Z on f_in fails the equality test in simulation, so
    // it counts as a mismatch, as a real tester would treat it.
    always_comb begin
        expected = ~((vec[4] & vec[1]) | (vec[0] & (vec[3] | vec[2])));
        mismatch = 1'b1;
        if (f_in == expected) begin
            mismatch = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Restarting from DONE behaves exactly like a start from IDLE.
                    if (start) begin
                        state            <= SETTLE;
                        vec              <= '0;
                        cnt              <= CNT_INIT;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    if (mismatch) begin
                        // At most 32 increments per sweep, so 6 bits cannot overflow.
                        err_count <= err_count + 6'd1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == 5'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec   <= vec + 5'd1;
                        cnt   <= CNT_INIT;
                        state <= SETTLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_computef_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_computef_sweep_checker
//
// Scoreboard bench. Each start pulse pushes the expected sweep result
// (counts, first failing vector, completion cycle, busy length) into a queue.
// A monitor per DUT pops and compares when done rises. dut0 uses the default
// settle time and a selectable function-block model: correct, stuck-0,
// stuck-1 or inverted. dut1 uses SETTLE_CYCLES=1 with a correct block.
// ---------------------------------------------------------------------------
module tb_computef_sweep_checker;

    typedef struct {
        logic [31:0] errs;
        logic [31:0] ffv;
        logic [31:0] ffvalid;
        logic [31:0] pass;
        logic [31:0] done_cyc;
        logic [31:0] busy_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    int unsigned mode = 0;
    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    logic       a0, b0, c0, d0, e0, f0, busy0, done0, pass0, ffvalid0;
    logic [5:0] err0;
    logic [4:0] ffv0;
    logic       a1, b1, c1, d1, e1, f1, busy1, done1, pass1, ffvalid1;
    logic [5:0] err1;
    logic [4:0] ffv1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic golden(input logic a, b, c, d, e);
        return ~((a & d) | (e & (b | c)));
    endfunction

    // Function-block models attached to the DUT outputs.
    always_comb begin
        case (mode)
            0:       f0 = golden(a0, b0, c0, d0, e0);
            1:       f0 = 1'b0;
            2:       f0 = 1'b1;
            default: f0 = ~golden(a0, b0, c0, d0, e0);
        endcase
    end
    assign f1 = golden(a1, b1, c1, d1, e1);

    computef_sweep_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvalid0)
    );

    computef_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_result(input string tag, input exp_t ex, input logic [31:0] errs,
                                input logic [31:0] ffv, input logic [31:0] ffvalid,
                                input logic [31:0] pass, input logic [31:0] bcnt);
        chk({tag, "_err_count"}, errs, ex.errs);
        chk({tag, "_first_fail_valid"}, ffvalid, ex.ffvalid);
        if (ex.ffvalid == 1) chk({tag, "_first_fail_vec"}, ffv, ex.ffv);
        chk({tag, "_pass"}, pass, ex.pass);
        chk({tag, "_done_cycle"}, cyc, ex.done_cyc);
        chk({tag, "_busy_cycles"}, bcnt, ex.busy_cycles);
    endtask

    // Monitor for dut0.
    int unsigned bcnt0 = 0;
    logic        dq0 = 1'b0;
    always @(negedge clk) begin
        exp_t ex;
        if (!rst_n) begin
            bcnt0 = 0;
            dq0   = 1'b0;
        end else begin
            if (busy0) bcnt0++;
            if (done0 && !dq0) begin
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut0_unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
                end else begin
                    ex = q0.pop_front();
                    check_result("dut0", ex, 32'(err0), 32'(ffv0), 32'(ffvalid0), 32'(pass0), bcnt0);
                end
                bcnt0 = 0;
            end
            dq0 = done0;
        end
    end

    // Monitor for dut1.
    int unsigned bcnt1 = 0;
    logic        dq1 = 1'b0;
    always @(negedge clk) begin
        exp_t ex;
        if (!rst_n) begin
            bcnt1 = 0;
            dq1   = 1'b0;
        end else begin
            if (busy1) bcnt1++;
            if (done1 && !dq1) begin
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut1_unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
                end else begin
                    ex = q1.pop_front();
                    check_result("dut1", ex, 32'(err1), 32'(ffv1), 32'(ffvalid1), 32'(pass1), bcnt1);
                end
                bcnt1 = 0;
            end
            dq1 = done1;
        end
    end

    // Issue a start pulse and push the expected outcome. Returns on the
    // negedge after the accepting edge.
    task automatic pulse_start(input int sel, input int unsigned errs, input int unsigned ffv,
                               input int unsigned ffvalid, input int unsigned pass);
        exp_t ex;
        int unsigned lat;
        @(negedge clk);
        lat            = (sel == 0) ? 96 : 64;
        ex.errs        = errs;
        ex.ffv         = ffv;
        ex.ffvalid     = ffvalid;
        ex.pass        = pass;
        ex.done_cyc    = cyc + 1 + lat;
        ex.busy_cycles = lat;
        if (sel == 0) begin
            q0.push_back(ex);
            start0 = 1'b1;
        end else begin
            q1.push_back(ex);
            start1 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input string name);
        logic dn;
        dn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            dn = (sel == 0) ? done0 : done1;
            if (dn) break;
        end
        chk({name, "_reached_done"}, 32'(dn), 1);
    endtask

    initial begin
        // Reset state of both instances.
        repeat (2) @(negedge clk);
        chk("reset_dut0_outputs", 32'({a0, b0, c0, d0, e0, busy0, done0, pass0, err0, ffv0, ffvalid0}), 0);
        chk("reset_dut1_outputs", 32'({a1, b1, c1, d1, e1, busy1, done1, pass1, err1, ffv1, ffvalid1}), 0);
        rst_n = 1'b1;

        // Correct block: clean sweep.
        mode = 0;
        pulse_start(0, 0, 0, 0, 1);
        chk("busy_after_start", 32'(busy0), 1);
        wait_done(0, "clean");
        chk("done_holds_vec31", 32'({a0, b0, c0, d0, e0}), 31);

        // F stuck at 0, started from DONE.
        mode = 1;
        pulse_start(0, 15, 0, 1, 0);
        chk("done_drops_on_restart", 32'(done0), 0);
        wait_done(0, "stuck0");

        // F stuck at 1: first vector with exp=0 is 00101.
        mode = 2;
        pulse_start(0, 17, 5, 1, 0);
        wait_done(0, "stuck1");

        // Inverted block: every vector fails.
        mode = 3;
        pulse_start(0, 32, 0, 1, 0);
        wait_done(0, "inverted");

        // Restart from DONE clears counters; mid-sweep start is ignored.
        mode = 0;
        pulse_start(0, 0, 0, 0, 1);
        chk("restart_clears_err_count", 32'(err0), 0);
        chk("restart_clears_ffvalid", 32'(ffvalid0), 0);
        repeat (50) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, "midsweep_start");

        // Asynchronous reset 40 cycles into a faulty sweep.
        mode = 1;
        pulse_start(0, 15, 0, 1, 0);
        repeat (39) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("async_reset_outputs", 32'({a0, b0, c0, d0, e0, busy0, done0, pass0, err0, ffv0, ffvalid0}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy0), 0);
        chk("idle_after_reset_done", 32'(done0), 0);
        mode = 0;
        pulse_start(0, 0, 0, 0, 1);
        wait_done(0, "after_reset");

        // SETTLE_CYCLES=1 instance: 64-cycle sweep.
        pulse_start(1, 0, 0, 0, 1);
        wait_done(1, "settle1");

        repeat (4) @(negedge clk);
        chk("dut0_queue_drained", 32'(q0.size()), 0);
        chk("dut1_queue_drained", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
